// File: rtl/pool_a1_cu.sv
// Control unit for the first 2x2 average-pooling stage: walks a 28x28 input map window by window,
// strobes the pooling accumulator and hands 14x14 results to the next stage's ping-pong memory.
module pool_a1_cu #(
  parameter int DATA_WIDTH            = 32,
  parameter int IFM_SIZE              = 28,
  parameter int IFM_DEPTH             = 6,
  parameter int KERNAL_SIZE           = 2,
  parameter int PIPE_LATENCY          = 3,
  parameter int IFM_SIZE_NEXT         = IFM_SIZE / KERNAL_SIZE,
  parameter int ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE),
  parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start_from_previous,
  input  logic                             end_from_next,
  output logic                             end_to_previous,
  output logic                             ifm_enable_read_current,
  output logic [ADDRESS_SIZE_IFM-1:0]      ifm_address_read_current,
  output logic                             ifm_sel_current,
  output logic                             pool_acc_clear,
  output logic                             pool_acc_enable,
  output logic                             ifm_enable_write_next,
  output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ifm_address_write_next,
  output logic                             start_to_next,
  output logic                             ifm_sel_next,
  output logic                             layer_done,
  output logic                             ready
);

  localparam int KW = (KERNAL_SIZE > 1) ? $clog2(KERNAL_SIZE) : 1;
  localparam int CW = (IFM_SIZE_NEXT > 1) ? $clog2(IFM_SIZE_NEXT) : 1;
  localparam int DW = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;
  localparam int MW = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(KERNAL_SIZE - 1);
  localparam logic [CW-1:0] C_LAST = CW'(IFM_SIZE_NEXT - 1);
  localparam logic [DW-1:0] D_LAST = DW'(PIPE_LATENCY - 1);
  localparam logic [MW-1:0] M_LAST = MW'(IFM_DEPTH - 1);
  localparam logic [ADDRESS_SIZE_NEXT_IFM-1:0] W_LAST =
    ADDRESS_SIZE_NEXT_IFM'(IFM_SIZE_NEXT * IFM_SIZE_NEXT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_OUT, S_READ, S_DRAIN} mainState_t;
  typedef enum logic {O_IDLE, O_WAIT} outState_t;

  mainState_t r_state, w_stateNext;
  outState_t  r_oState, w_oStateNext;

  logic [KW-1:0] r_kx, r_ky;
  logic [CW-1:0] r_c, r_r;
  logic [DW-1:0] r_drainCnt;
  logic [MW-1:0] r_mapCnt;
  logic [PIPE_LATENCY-1:0] r_wrPipe;
  logic [ADDRESS_SIZE_NEXT_IFM-1:0] r_wrAddr;
  logic r_selCur, r_selNext, r_accEn, r_accClr;

  logic w_rdEn, w_lastElem, w_lastRead, w_drainDone, w_wrEn, w_wrTick, w_handoff;

  assign w_rdEn      = (r_state == S_READ);
  assign w_lastElem  = (r_kx == K_LAST) && (r_ky == K_LAST);
  assign w_lastRead  = w_lastElem && (r_c == C_LAST) && (r_r == C_LAST);
  assign w_drainDone = (r_state == S_DRAIN) && (r_drainCnt == D_LAST);
  assign w_wrEn      = r_wrPipe[PIPE_LATENCY-1];
  assign w_wrTick    = w_wrEn && (r_wrAddr == W_LAST);
  assign w_handoff   = (r_oState == O_WAIT) && end_from_next;

  assign ifm_address_read_current = ADDRESS_SIZE_IFM'(
    (KERNAL_SIZE * int'(r_r) + int'(r_ky)) * IFM_SIZE + KERNAL_SIZE * int'(r_c) + int'(r_kx));
  assign ifm_enable_read_current = w_rdEn;
  assign ifm_sel_current         = r_selCur;
  assign pool_acc_clear          = r_accClr;
  assign pool_acc_enable         = r_accEn;
  assign ifm_enable_write_next   = w_wrEn;
  assign ifm_address_write_next  = r_wrAddr;
  assign ifm_sel_next            = r_selNext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_oState <= O_IDLE;
    end else begin
      r_state  <= w_stateNext;
      r_oState <= w_oStateNext;
    end
  end

  // A start that arrives while the previous result still awaits handoff parks in WAIT_OUT,
  // so the output bank is never overwritten before the next stage has taken it.
  always_comb begin
    w_stateNext = r_state;
    ready       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start_from_previous)
          w_stateNext = (r_oState == O_IDLE) ? S_READ : S_WAIT_OUT;
      end
      S_WAIT_OUT: if (r_oState == O_IDLE) w_stateNext = S_READ;
      S_READ:     if (w_lastRead) w_stateNext = S_DRAIN;
      S_DRAIN:    if (w_drainDone) w_stateNext = S_IDLE;
      default:    w_stateNext = S_IDLE;
    endcase
  end

  always_comb begin
    w_oStateNext    = r_oState;
    start_to_next   = 1'b0;
    layer_done      = 1'b0;
    end_to_previous = (r_state == S_IDLE) && (r_oState == O_IDLE);
    unique case (r_oState)
      O_IDLE: if (w_wrTick) w_oStateNext = O_WAIT;
      O_WAIT: begin
        if (end_from_next) begin
          start_to_next = 1'b1;
          layer_done    = (r_mapCnt == M_LAST);
          w_oStateNext  = O_IDLE;
        end
      end
      default: w_oStateNext = O_IDLE;
    endcase
  end

  // Window walk: kx fastest, then ky, then window column c, then window row r.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_kx <= '0;
      r_ky <= '0;
      r_c  <= '0;
      r_r  <= '0;
    end else if (w_rdEn) begin
      if (r_kx != K_LAST) begin
        r_kx <= r_kx + 1'b1;
      end else begin
        r_kx <= '0;
        if (r_ky != K_LAST) begin
          r_ky <= r_ky + 1'b1;
        end else begin
          r_ky <= '0;
          if (r_c != C_LAST) begin
            r_c <= r_c + 1'b1;
          end else begin
            r_c <= '0;
            r_r <= (r_r == C_LAST) ? '0 : r_r + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drainCnt <= '0;
      r_selCur   <= 1'b0;
    end else begin
      if (r_state == S_DRAIN)
        r_drainCnt <= w_drainDone ? '0 : r_drainCnt + 1'b1;
      else
        r_drainCnt <= '0;
      if (w_drainDone)
        r_selCur <= ~r_selCur;
    end
  end

  // Read data arrives one cycle after the address, so accumulator strobes are the read
  // controls delayed by one; the write strobe follows the datapath latency instead.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_accEn  <= 1'b0;
      r_accClr <= 1'b0;
      r_wrPipe <= '0;
    end else begin
      r_accEn     <= w_rdEn;
      r_accClr    <= w_rdEn && (r_kx == '0) && (r_ky == '0);
      r_wrPipe[0] <= w_rdEn && w_lastElem;
      for (int i = 1; i < PIPE_LATENCY; i++)
        r_wrPipe[i] <= r_wrPipe[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrAddr  <= '0;
      r_selNext <= 1'b0;
      r_mapCnt  <= '0;
    end else begin
      if (w_wrEn)
        r_wrAddr <= w_wrTick ? '0 : r_wrAddr + 1'b1;
      if (w_handoff) begin
        r_selNext <= ~r_selNext;
        r_mapCnt  <= (r_mapCnt == M_LAST) ? '0 : r_mapCnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pool_a1_cu.sv
// Directed testbench for pool_a1_cu: single map, mid-map reset, backpressure with a parked
// start, and a full six-map layer.
module tb_pool_a1_cu;

  logic clk = 1'b0;
  logic reset, start_from_previous, end_from_next;
  logic end_to_previous, ifm_enable_read_current, ifm_sel_current;
  logic pool_acc_clear, pool_acc_enable, ifm_enable_write_next;
  logic start_to_next, ifm_sel_next, layer_done, ready;
  logic [9:0] ifm_address_read_current;
  logic [7:0] ifm_address_write_next;

  int total = 0;
  int bad   = 0;

  pool_a1_cu dut (
    .clk                      (clk),
    .reset                    (reset),
    .start_from_previous      (start_from_previous),
    .end_from_next            (end_from_next),
    .end_to_previous          (end_to_previous),
    .ifm_enable_read_current  (ifm_enable_read_current),
    .ifm_address_read_current (ifm_address_read_current),
    .ifm_sel_current          (ifm_sel_current),
    .pool_acc_clear           (pool_acc_clear),
    .pool_acc_enable          (pool_acc_enable),
    .ifm_enable_write_next    (ifm_enable_write_next),
    .ifm_address_write_next   (ifm_address_write_next),
    .start_to_next            (start_to_next),
    .ifm_sel_next             (ifm_sel_next),
    .layer_done               (layer_done),
    .ready                    (ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, where outputs are stable.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic en);
    start_from_previous = st;
    end_from_next       = en;
  endtask

  task automatic pulseStart(input logic en);
    applyStimulus(1'b1, en);
    stepCycle();
    applyStimulus(1'b0, en);
  endtask

  task automatic doReset();
    reset = 1'b1;
    stepCycle();
    stepCycle();
    reset = 1'b0;
    stepCycle();
  endtask

  int rdAddr[784];
  int expWin[4];
  int rdCnt, wrCnt, clrCnt, clrBad, accCnt, firstWr, wrSeqBad, stnCnt, stnCyc, ldCnt, ldCyc;
  int started;
  bit found;

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1);
    stepCycle();
    stepCycle();
    checkOutput("rst_rd_en", int'(ifm_enable_read_current), 0);
    checkOutput("rst_ready", int'(ready), 1);
    checkOutput("rst_end_to_prev", int'(end_to_previous), 1);
    checkOutput("rst_wr_en", int'(ifm_enable_write_next), 0);
    reset = 1'b0;
    rdCnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (ifm_enable_read_current) rdCnt++;
      stepCycle();
    end
    checkOutput("idle_no_reads", rdCnt, 0);
    checkOutput("idle_sel_cur", int'(ifm_sel_current), 0);
    checkOutput("idle_sel_next", int'(ifm_sel_next), 0);

    // Single map with the next stage always ready.
    pulseStart(1'b1);
    rdCnt = 0; wrCnt = 0; clrCnt = 0; clrBad = 0; accCnt = 0;
    firstWr = -1; wrSeqBad = 0; stnCnt = 0; stnCyc = -1;
    for (int cyc = 0; cyc < 820; cyc++) begin
      if (ifm_enable_read_current) begin
        if (rdCnt < 784) rdAddr[rdCnt] = int'(ifm_address_read_current);
        rdCnt++;
      end
      if (pool_acc_enable) accCnt++;
      if (pool_acc_clear) begin
        clrCnt++;
        if (cyc % 4 != 1) clrBad++;
      end
      if (ifm_enable_write_next) begin
        if (firstWr < 0) firstWr = cyc;
        if (int'(ifm_address_write_next) != wrCnt) wrSeqBad++;
        wrCnt++;
      end
      if (start_to_next) begin
        stnCnt++;
        stnCyc = cyc;
      end
      stepCycle();
    end
    expWin = '{0, 1, 28, 29};
    for (int i = 0; i < 4; i++) checkOutput("rd_win0", rdAddr[i], expWin[i]);
    expWin = '{2, 3, 30, 31};
    for (int i = 0; i < 4; i++) checkOutput("rd_win1", rdAddr[4 + i], expWin[i]);
    expWin = '{56, 57, 84, 85};
    for (int i = 0; i < 4; i++) checkOutput("rd_row1", rdAddr[56 + i], expWin[i]);
    expWin = '{754, 755, 782, 783};
    for (int i = 0; i < 4; i++) checkOutput("rd_last_win", rdAddr[780 + i], expWin[i]);
    checkOutput("rd_count", rdCnt, 784);
    checkOutput("acc_en_count", accCnt, 784);
    checkOutput("clr_count", clrCnt, 196);
    checkOutput("clr_phase_bad", clrBad, 0);
    checkOutput("first_wr_cycle", firstWr, 6);
    checkOutput("wr_count", wrCnt, 196);
    checkOutput("wr_addr_seq_bad", wrSeqBad, 0);
    checkOutput("stn_count", stnCnt, 1);
    checkOutput("stn_cycle", stnCyc, 787);
    checkOutput("map1_sel_next", int'(ifm_sel_next), 1);
    checkOutput("map1_sel_cur", int'(ifm_sel_current), 1);
    checkOutput("map1_end_to_prev", int'(end_to_previous), 1);
    checkOutput("map1_layer_done", int'(layer_done), 0);

    // Reset partway through a map.
    pulseStart(1'b1);
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (ifm_enable_read_current && ifm_address_read_current == 10'd300) begin
        found = 1'b1;
        break;
      end
      stepCycle();
    end
    checkOutput("reach_addr300", int'(found), 1);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_rd_en", int'(ifm_enable_read_current), 0);
    checkOutput("mid_rst_rd_addr", int'(ifm_address_read_current), 0);
    checkOutput("mid_rst_acc_en", int'(pool_acc_enable), 0);
    checkOutput("mid_rst_sel_cur", int'(ifm_sel_current), 0);
    checkOutput("mid_rst_sel_next", int'(ifm_sel_next), 0);
    checkOutput("mid_rst_wr_addr", int'(ifm_address_write_next), 0);
    checkOutput("mid_rst_ready", int'(ready), 1);
    stepCycle();
    reset = 1'b0;
    stepCycle();
    pulseStart(1'b0);
    checkOutput("restart_rd_en", int'(ifm_enable_read_current), 1);
    checkOutput("restart_rd_addr", int'(ifm_address_read_current), 0);
    checkOutput("restart_sel_cur", int'(ifm_sel_current), 0);

    // Same map finishes against a stalled next stage.
    wrCnt = 0; stnCnt = 0;
    for (int cyc = 0; cyc < 820; cyc++) begin
      if (ifm_enable_write_next) wrCnt++;
      if (start_to_next) stnCnt++;
      stepCycle();
    end
    checkOutput("bp_wr_count", wrCnt, 196);
    checkOutput("bp_no_stn", stnCnt, 0);
    checkOutput("bp_end_to_prev", int'(end_to_previous), 0);
    checkOutput("bp_ready", int'(ready), 1);
    checkOutput("bp_sel_cur", int'(ifm_sel_current), 1);

    // A new start while the handoff is pending must wait for it.
    pulseStart(1'b0);
    rdCnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (ifm_enable_read_current) rdCnt++;
      stepCycle();
    end
    checkOutput("parked_no_reads", rdCnt, 0);
    checkOutput("parked_ready", int'(ready), 0);
    end_from_next = 1'b1;
    #1;
    checkOutput("bp_stn_pulse", int'(start_to_next), 1);
    checkOutput("bp_layer_done", int'(layer_done), 0);
    stepCycle();
    checkOutput("bp_sel_next", int'(ifm_sel_next), 1);
    checkOutput("parked_rd_still_off", int'(ifm_enable_read_current), 0);
    stepCycle();
    checkOutput("parked_rd_begins", int'(ifm_enable_read_current), 1);
    checkOutput("parked_rd_addr", int'(ifm_address_read_current), 0);
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (end_to_previous) begin
        found = 1'b1;
        break;
      end
      stepCycle();
    end
    checkOutput("parked_map_done", int'(found), 1);

    // Full layer of six maps back to back.
    doReset();
    started = 0; stnCnt = 0; ldCnt = 0; stnCyc = -1; ldCyc = -2;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (start_to_next) begin
        stnCnt++;
        stnCyc = cyc;
      end
      if (layer_done) begin
        ldCnt++;
        ldCyc = cyc;
      end
      if (stnCnt == 6) break;
      if (end_to_previous && started < 6) begin
        applyStimulus(1'b1, 1'b1);
        started++;
      end else begin
        applyStimulus(1'b0, 1'b1);
      end
      stepCycle();
    end
    applyStimulus(1'b0, 1'b1);
    stepCycle();
    checkOutput("layer_stn_count", stnCnt, 6);
    checkOutput("layer_done_count", ldCnt, 1);
    checkOutput("layer_done_with_6th", ldCyc, stnCyc);
    checkOutput("layer_sel_cur", int'(ifm_sel_current), 0);
    checkOutput("layer_sel_next", int'(ifm_sel_next), 0);
    checkOutput("layer_end_to_prev", int'(end_to_previous), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pool_a1_cu.md
Name: pool_a1_cu

Overview:
Control unit for the first 2x2 average-pooling stage. It sits directly downstream of the first convolution stage. It consumes one 28x28 feature map at a time from the convolution stage's ping-pong output memory and reads it window by window. It drives the pooling datapath's accumulate and clear strobes, and writes 14x14 results into the next stage's ping-pong memory, using the same start/end handshake on both sides.

Parameters:
DATA_WIDTH, 32, datapath word width (pass-through only; no arithmetic in this block)
IFM_SIZE, 28, input map edge length
IFM_DEPTH, 6, maps per layer (one map handed over per start)
KERNAL_SIZE, 2, pooling window edge; stride equals KERNAL_SIZE
PIPE_LATENCY, 3, cycles from the read of a window's last element to its result being writable
IFM_SIZE_NEXT, IFM_SIZE/KERNAL_SIZE, output map edge
ADDRESS_SIZE_IFM, $clog2(IFM_SIZE*IFM_SIZE), input address width
ADDRESS_SIZE_NEXT_IFM, $clog2(IFM_SIZE_NEXT*IFM_SIZE_NEXT), output address width

Ports:
clk  in  1  clock; single clock domain
reset  in  1  asynchronous, active-high reset
start_from_previous  in  1  1-cycle pulse: a full input map is available in bank ifm_sel_current
end_from_next  in  1  level: next stage can accept a new map
end_to_previous  out  1  level: this block can accept a new input map
ifm_enable_read_current  out  1  input memory read enable
ifm_address_read_current  out  ADDRESS_SIZE_IFM  input read address
ifm_sel_current  out  1  input bank being read
pool_acc_clear  out  1  aligned with read data: load the accumulator (first element of a window)
pool_acc_enable  out  1  aligned with read data: accumulate the element
ifm_enable_write_next  out  1  output memory write enable
ifm_address_write_next  out  ADDRESS_SIZE_NEXT_IFM  output write address
start_to_next  out  1  1-cycle pulse: output map complete
ifm_sel_next  out  1  output bank being written
layer_done  out  1  1-cycle pulse after IFM_DEPTH maps have been handed downstream
ready  out  1  high in IDLE

Behaviour:
- Reset: every output is 0, every counter is 0, both FSMs are in their idle states; end_to_previous is then 1 and ready is 1.
- Main FSM states:
  - IDLE: a start_from_previous pulse moves to READ if no output handoff is pending; otherwise it moves to WAIT_OUT, with the start latched.
  - WAIT_OUT: waits until the output FSM returns to O_IDLE, then moves to READ.
  - READ: issues one read per cycle with ifm_enable_read_current=1. After the last address is issued it moves to DRAIN.
  - DRAIN: counts PIPE_LATENCY cycles, then moves to IDLE and toggles ifm_sel_current.
- Read order uses the counters kx, ky (0..KERNAL_SIZE-1), c, r (0..IFM_SIZE_NEXT-1).
  - Address = (KERNAL_SIZE*r+ky)*IFM_SIZE + KERNAL_SIZE*c + kx.
  - kx increments fastest, then ky, then c, then r.
  - All counters wrap to 0 after the final window. Exactly IFM_SIZE*IFM_SIZE reads per map.
- Strobe timing (memory read latency is 1 cycle):
  - pool_acc_enable = read enable delayed 1 cycle.
  - pool_acc_clear = (read enable & kx==0 & ky==0) delayed 1 cycle.
  - ifm_enable_write_next = (read enable & last element of window) delayed PIPE_LATENCY cycles.
- Write address:
  - Increments after each write.
  - The write at IFM_SIZE_NEXT*IFM_SIZE_NEXT-1 wraps it to 0 and raises the internal write tick.
- Output FSM:
  - O_IDLE: the write tick moves to O_WAIT.
  - O_WAIT: when end_from_next=1, start_to_next=1 combinationally for that cycle, ifm_sel_next toggles at the next edge, and the FSM returns to O_IDLE.
  - Map counter increments on each start_to_next. On reaching IFM_DEPTH it wraps to 0 and layer_done pulses in the same cycle as start_to_next.
- end_to_previous = (main state == IDLE) & (output FSM == O_IDLE).
- Boundary cases:
  - start_from_previous in READ, DRAIN or WAIT_OUT is ignored; the upstream protocol forbids it.
  - end_from_next already high when O_WAIT is entered: handoff completes in that first cycle.
  - Reset asserted mid-map: immediate return to the reset state; the partial map is discarded and bank selects return to 0.

Test Plan:
- Reset then idle: outputs 0, ready=1, end_to_previous=1; no reads without a start pulse.
- Single map, end_from_next held 1:
  - first reads are 0,1,28,29, then 2,3,30,31; row 1 starts 56,57,84,85; final window 754,755,782,783.
  - pool_acc_clear lands on cycles 1,5,9,...
  - first write (address 0) occurs on cycle 3+PIPE_LATENCY=6 after the first read.
  - 196 writes total; start_to_next pulses once; ifm_sel_next toggles to 1; ifm_sel_current toggles to 1.
- Backpressure: end_from_next=0 at map end -> stays in O_WAIT, end_to_previous=0; raise it 50 cycles later -> start_to_next pulses that cycle and end_to_previous returns to 1.
- Six back-to-back maps: layer_done pulses exactly once, coincident with the 6th start_to_next; the map counter returns to 0; both bank selects end at 0.
- Reset asserted at read address 300: all outputs 0 immediately; a following start reads again from address 0 in bank 0.
